// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline stage types, default field widths and bubble encoding
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } stage_state_e;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int STAGE_W = INSTR_W + 2 * ADDR_W;

    // addi x0, x0, 0 -- decode-stage instances present this as their bubble
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional 2-entry skid, flush and stall counter
//   clk, reset           clock and synchronous active-high reset
//   flush                drop held and incoming entries this cycle
//   in_valid/in_data     upstream entry, in_ready back-pressure to upstream
//   out_valid/out_data   held entry (out_data = BUBBLE when empty), out_ready from downstream
//   stall_cnt            saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH  = STAGE_W,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, drain;

    assign out_valid = state_q != ST_EMPTY;
    assign out_data  = main_q;
    // skid mode: ready depends only on registered state, cutting the ready path to upstream
    assign in_ready  = SKID ? state_q != ST_SKID : (out_ready | ~out_valid);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept && SKID) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (out_valid && !out_ready && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage variants (SKID=0, SKID=1, SKID=1 with 4-bit counter) against a FIFO model
module tb_pipe_stage_reg;

    localparam logic [15:0] BUB = 16'hB0B0;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        rdy0, rdy1, rdy2, v0, v1, v2;
    logic [15:0] d0, d1, d2, c0, c1;
    logic [3:0]  c2;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(16), .SKID(1'b0), .BUBBLE(BUB), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(v0), .out_data(d0), .out_ready(out_ready), .stall_cnt(c0));
    pipe_stage_reg #(.WIDTH(16), .SKID(1'b1), .BUBBLE(BUB), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(v1), .out_data(d1), .out_ready(out_ready), .stall_cnt(c1));
    pipe_stage_reg #(.WIDTH(16), .SKID(1'b1), .BUBBLE(BUB), .CNT_W(4)) u4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy2), .out_valid(v2), .out_data(d2), .out_ready(out_ready), .stall_cnt(c2));

    // model: each stage is a FIFO of capacity 1 (k=0) or 2 (k=1,2) plus a stall counter
    logic [15:0] mdat [3][2];
    int          mn [3];
    int          mc [3];
    bit          known [3];

    task automatic cmp(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic rdy, input logic vld, input logic [15:0] dat, input logic [15:0] cnt);
        logic er;
        int   maxc;
        maxc = (k == 2) ? 15 : 65535;
        er = (k != 0) ? (mn[k] < 2) : (out_ready || mn[k] == 0);
        if (known[k]) begin
            cmp("in_ready", k, {15'd0, rdy}, {15'd0, er});
            cmp("out_valid", k, {15'd0, vld}, {15'd0, mn[k] > 0});
            cmp("out_data", k, dat, mn[k] > 0 ? mdat[k][0] : BUB);
            cmp("stall_cnt", k, cnt, 16'(mc[k]));
        end
        if (reset) begin
            mn[k] = 0;
            mc[k] = 0;
            known[k] = 1'b1;
        end else if (known[k]) begin
            if (mn[k] > 0 && !out_ready && mc[k] < maxc) mc[k]++;
            if (flush) begin
                mn[k] = 0;
            end else begin
                if (mn[k] > 0 && out_ready) begin
                    mdat[k][0] = mdat[k][1];
                    mn[k]--;
                end
                if (in_valid && er) begin
                    mdat[k][mn[k]] = in_data;
                    mn[k]++;
                end
            end
        end
    endtask

    // inputs change 2 units after posedge, so at negedge they are the ones the next edge will see
    always @(negedge clk) begin
        model_step(0, rdy0, v0, d0, c0);
        model_step(1, rdy1, v1, d1, c1);
        model_step(2, rdy2, v2, d2, {12'd0, c2});
    end

    task automatic cyc(input logic r, input logic f, input logic v, input logic [15:0] d, input logic o);
        reset = r;
        flush = f;
        in_valid = v;
        in_data = d;
        out_ready = o;
        @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cmp("rst_valid", 1, {15'd0, v1}, 16'd0);
        cmp("rst_data", 1, d1, BUB);
        cmp("rst_cnt", 1, c1, 16'd0);
        cmp("rst_ready", 1, {15'd0, rdy1}, 16'd1);
        cmp("rst_ready", 0, {15'd0, rdy0}, 16'd1);

        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 1, 16'(i), 1);
            cmp("stream_data", 1, d1, 16'(i));
            cmp("stream_data", 0, d0, 16'(i));
            cmp("stream_ready", 1, {15'd0, rdy1}, 16'd1);
        end
        cyc(0, 0, 0, 0, 1);
        cmp("stream_end", 1, {15'd0, v1}, 16'd0);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 16'h000A, 0);
        cyc(0, 0, 1, 16'h000B, 0);
        cmp("skid_ready", 1, {15'd0, rdy1}, 16'd0);
        cmp("skid_hold", 1, d1, 16'h000A);
        repeat (4) cyc(0, 0, 0, 0, 0);
        cmp("stall5", 1, c1, 16'd5);
        cmp("hold5", 1, d1, 16'h000A);
        cmp("s0_hold", 0, d0, 16'h000A);
        cyc(0, 0, 0, 0, 1);
        cmp("drain_b", 1, d1, 16'h000B);
        cmp("s0_no_b", 0, {15'd0, v0}, 16'd0);
        cyc(0, 0, 0, 0, 1);
        cmp("drained", 1, {15'd0, v1}, 16'd0);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 16'h000A, 0);
        cyc(0, 0, 1, 16'h000B, 0);
        cyc(0, 1, 1, 16'h000C, 0);
        cmp("flush_valid", 1, {15'd0, v1}, 16'd0);
        cmp("flush_data", 1, d1, BUB);
        cmp("flush_cnt", 1, c1, 16'd2);
        cyc(0, 0, 0, 0, 1);
        cmp("flush_gone", 1, {15'd0, v1}, 16'd0);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 16'h0005, 0);
        cmp("s0_ready", 0, {15'd0, rdy0}, 16'd0);
        cyc(0, 0, 1, 16'h0006, 0);
        cyc(0, 0, 1, 16'h0006, 0);
        cmp("s0_payload", 0, d0, 16'h0005);
        cyc(0, 0, 0, 0, 1);
        cmp("s0_single", 0, {15'd0, v0}, 16'd0);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 16'h0007, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);
        cmp("sat4", 2, {12'd0, c2}, 16'd15);
        cmp("cnt20", 1, c1, 16'd20);
        cyc(1, 0, 1, 16'h0008, 1);
        cmp("midrst_valid", 1, {15'd0, v1}, 16'd0);
        cmp("midrst_data", 1, d1, BUB);
        cmp("midrst_cnt", 2, {12'd0, c2}, 16'd0);
        cmp("midrst_ready", 1, {15'd0, rdy1}, 16'd1);

        repeat (3000)
            cyc(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 10) < 7,
                16'($urandom), ($urandom % 10) < 6);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
